// File: rtl/seq_mul_pkg.sv
// Shared constants and state type for the sequential shift-add multiplier.
package seq_mul_pkg;

    localparam int unsigned SEQ_MUL_WIDTH = 16;
    localparam int unsigned SEQ_MUL_CNT_W = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_multiplier_if.sv
// Request/result bundle between the execute path and seq_multiplier.
interface seq_multiplier_if
    import seq_mul_pkg::*;
#(
    parameter int unsigned WIDTH = SEQ_MUL_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] prod_hi;
    logic [WIDTH-1:0] prod_lo;

    modport master (
        output start, op_a, op_b,
        input  ready, busy, done, prod_hi, prod_lo
    );

    modport slave (
        input  start, op_a, op_b,
        output ready, busy, done, prod_hi, prod_lo
    );

endinterface

// File: rtl/mul_sign_fix.sv
// Combinational two's-complement helper: operand magnitudes, result sign and
// final negation for the signed multiply build.
module mul_sign_fix #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    input  logic               neg,
    input  logic [2*WIDTH-1:0] prod_raw,
    output logic [WIDTH-1:0]   mag_a,
    output logic [WIDTH-1:0]   mag_b,
    output logic               sign_diff,
    output logic [2*WIDTH-1:0] prod_out
);

    // The most negative value maps onto itself, which is its correct unsigned magnitude.
    assign mag_a     = op_a[WIDTH-1] ? (~op_a + 1'b1) : op_a;
    assign mag_b     = op_b[WIDTH-1] ? (~op_b + 1'b1) : op_b;
    assign sign_diff = op_a[WIDTH-1] ^ op_b[WIDTH-1];
    assign prod_out  = neg ? (~prod_raw + 1'b1) : prod_raw;

endmodule

// File: rtl/seq_multiplier.sv
// Multi-cycle shift-add multiplier, WIDTH iterations per product.
// Define SEQ_MUL_SIGNED_EN for two's-complement operands (same latency).
module seq_multiplier
    import seq_mul_pkg::*;
#(
    parameter int unsigned WIDTH = SEQ_MUL_WIDTH,
    parameter int unsigned CNT_W = SEQ_MUL_CNT_W
) (
    input logic             clk,
    input logic             rst,
    seq_multiplier_if.slave bus
);

    state_t             state;
    state_t             state_nx;
    logic [CNT_W-1:0]   count;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   acc_hi_nx;
    logic [WIDTH-1:0]   acc_lo_nx;
    logic [WIDTH-1:0]   load_a;
    logic [WIDTH-1:0]   load_b;
    logic [2*WIDTH-1:0] result;
    logic               accept;
    logic               last;

    assign accept = ((state == S_IDLE) || (state == S_DONE)) && bus.start;
    assign last   = (state == S_CALC) && (count == CNT_W'(WIDTH - 1));

    // Carry out of the add lands in the top bit after the right shift.
    assign sum       = {1'b0, acc_hi} + (mplier[0] ? {1'b0, mcand} : '0);
    assign acc_hi_nx = sum[WIDTH:1];
    assign acc_lo_nx = {sum[0], acc_lo[WIDTH-1:1]};

`ifdef SEQ_MUL_SIGNED_EN
    logic neg;
    logic sign_diff;

    mul_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .op_a      (bus.op_a),
        .op_b      (bus.op_b),
        .neg       (neg),
        .prod_raw  ({acc_hi_nx, acc_lo_nx}),
        .mag_a     (load_a),
        .mag_b     (load_b),
        .sign_diff (sign_diff),
        .prod_out  (result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            neg <= 1'b0;
        end else if (accept) begin
            neg <= sign_diff;
        end
    end
`else
    assign load_a = bus.op_a;
    assign load_b = bus.op_b;
    assign result = {acc_hi_nx, acc_lo_nx};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (bus.start) state_nx = S_CALC;
            S_CALC:  if (last) state_nx = S_DONE;
            S_DONE:  state_nx = bus.start ? S_CALC : S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count       <= '0;
            mcand       <= '0;
            mplier      <= '0;
            acc_hi      <= '0;
            acc_lo      <= '0;
            bus.prod_hi <= '0;
            bus.prod_lo <= '0;
        end else if (accept) begin
            count  <= '0;
            mcand  <= load_a;
            mplier <= load_b;
            acc_hi <= '0;
            acc_lo <= '0;
        end else if (state == S_CALC) begin
            count  <= count + 1'b1;
            mplier <= mplier >> 1;
            acc_hi <= acc_hi_nx;
            acc_lo <= acc_lo_nx;
            if (last) begin
                {bus.prod_hi, bus.prod_lo} <= result;
            end
        end
    end

    assign bus.busy  = (state == S_CALC);
    assign bus.ready = (state == S_IDLE) || (state == S_DONE);
    assign bus.done  = (state == S_DONE);

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: cycle-level reference model plus
// directed vectors with literal expected products.
module tb_seq_multiplier;

    localparam int unsigned W = 16;

    logic clk = 1'b0;
    logic rst;

    seq_multiplier_if #(.WIDTH(W)) bus ();

    seq_multiplier #(.WIDTH(W), .CNT_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: fixed 16-edge latency, product from plain arithmetic.
    int          m_rem   = 0;
    logic        m_done  = 1'b0;
    logic [31:0] m_prod  = '0;
    logic [31:0] m_pend  = '0;
    bit          m_valid = 1'b0;

    function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
`ifdef SEQ_MUL_SIGNED_EN
        logic signed [31:0] p;
        p = $signed({{16{a[15]}}, a}) * $signed({{16{b[15]}}, b});
        return p;
`else
        return {16'b0, a} * {16'b0, b};
`endif
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_rem   <= 0;
            m_done  <= 1'b0;
            m_prod  <= '0;
            m_valid <= 1'b1;
        end else if (m_rem > 0) begin
            m_rem  <= m_rem - 1;
            m_done <= (m_rem == 1);
            if (m_rem == 1) m_prod <= m_pend;
        end else begin
            m_done <= 1'b0;
            if (bus.start) begin
                m_rem  <= int'(W);
                m_pend <= ref_mul(bus.op_a, bus.op_b);
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_ready", {31'b0, bus.ready}, {31'b0, (m_rem == 0)});
            check("model_busy", {31'b0, bus.busy}, {31'b0, (m_rem != 0)});
            check("model_done", {31'b0, bus.done}, {31'b0, m_done});
            check("model_prod", {bus.prod_hi, bus.prod_lo}, m_prod);
        end
    end

    // Called at a negedge with the DUT ready; returns at the negedge after the accept edge.
    task automatic accept(input logic [15:0] a, input logic [15:0] b);
        bus.start = 1'b1;
        bus.op_a  = a;
        bus.op_b  = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.op_a  = 16'($urandom);
        bus.op_b  = 16'($urandom);
    endtask

    task automatic wait_done(input string name, input logic [31:0] exp, input int exp_lat);
        int lat  = 0;
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            lat++;
            seen = bus.done;
        end
        check({name, "_done_seen"}, {31'b0, seen}, 32'd1);
        check({name, "_latency"}, 32'(lat), 32'(exp_lat));
        check({name, "_prod"}, {bus.prod_hi, bus.prod_lo}, exp);
    endtask

    task automatic count_dones(input string name, input int cycles);
        int n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.done) n++;
        end
        check({name, "_no_done"}, 32'(n), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op_a  = '0;
        bus.op_b  = '0;
        repeat (2) @(negedge clk);
        check("reset_ready", {31'b0, bus.ready}, 32'd1);
        check("reset_busy", {31'b0, bus.busy}, 32'd0);
        check("reset_done", {31'b0, bus.done}, 32'd0);
        check("reset_prod", {bus.prod_hi, bus.prod_lo}, 32'h0000_0000);
        rst = 1'b0;
        @(negedge clk);

        accept(16'h0003, 16'h0005);
        check("basic_busy", {31'b0, bus.busy}, 32'd1);
        wait_done("basic", 32'h0000_000F, 16);
        repeat (3) @(negedge clk);
        check("basic_hold", {bus.prod_hi, bus.prod_lo}, 32'h0000_000F);

        accept(16'hFFFF, 16'hFFFF);
`ifdef SEQ_MUL_SIGNED_EN
        wait_done("max", 32'h0000_0001, 16);
`else
        wait_done("max", 32'hFFFE_0001, 16);
`endif
        @(negedge clk);
        accept(16'h1234, 16'h0000);
        wait_done("zero", 32'h0000_0000, 16);
        @(negedge clk);

        // Second start during CALC cycle 5 must be dropped.
        accept(16'h0100, 16'h0100);
        repeat (4) @(negedge clk);
        bus.start = 1'b1;
        bus.op_a  = 16'h0002;
        bus.op_b  = 16'h0002;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("ignore", 32'h0001_0000, 11);
        count_dones("ignore", 20);

        accept(16'h0007, 16'h0009);
        wait_done("pre_b2b", 32'h0000_003F, 16);
        check("b2b_ready_in_done", {31'b0, bus.ready}, 32'd1);
        accept(16'h00FF, 16'h0101);
        check("b2b_busy", {31'b0, bus.busy}, 32'd1);
        check("b2b_prod_kept", {bus.prod_hi, bus.prod_lo}, 32'h0000_003F);
        wait_done("b2b", 32'h0000_FFFF, 16);
        @(negedge clk);

        accept(16'h1234, 16'h5678);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_ready", {31'b0, bus.ready}, 32'd1);
        check("midrst_busy", {31'b0, bus.busy}, 32'd0);
        check("midrst_done", {31'b0, bus.done}, 32'd0);
        check("midrst_prod", {bus.prod_hi, bus.prod_lo}, 32'h0000_0000);
        count_dones("midrst", 20);

`ifdef SEQ_MUL_SIGNED_EN
        accept(16'hFFFD, 16'h0005);
        wait_done("signed_neg", 32'hFFFF_FFF1, 16);
        @(negedge clk);
        accept(16'h8000, 16'h8000);
        wait_done("signed_min", 32'h4000_0000, 16);
        @(negedge clk);
`else
        accept(16'h8000, 16'h8000);
        wait_done("unsigned_msb", 32'h4000_0000, 16);
        @(negedge clk);
`endif

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got simulation still running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
- Multi-cycle 16-bit shift-add multiplier that consumes the latched operand held by the temporary-storage register (op_a) and a second operand from the register-file/accumulator path (op_b).
- Sits directly downstream of the temp register, on the execute path of the 16-bit processor.
- Produces a 32-bit product after a fixed latency and signals completion with a one-cycle pulse.

Parameters:
- WIDTH, 16, operand width; product is 2*WIDTH.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a multiply; sampled only when ready=1.
- op_a  input  WIDTH  multiplicand (from temp storage output).
- op_b  input  WIDTH  multiplier.
- ready  output  1  high in IDLE and DONE; start is accepted.
- busy  output  1  high in CALC.
- done  output  1  one-cycle pulse; product valid.
- prod_hi  output  WIDTH  upper half of product.
- prod_lo  output  WIDTH  lower half of product.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset (rst=1 at an edge): state=IDLE, count=0, prod_hi=prod_lo=0, done=0, busy=0, ready=1. Reset overrides start and any in-flight operation; a partial result is discarded and outputs read 0.
- States: IDLE, CALC, DONE.
  - IDLE: if start=1 → CALC.
  - CALC: stays for WIDTH edges, then → DONE.
  - DONE: if start=1 → CALC (back-to-back start); otherwise → IDLE.
- Accept at edge N (ready=1 and start=1):
  - op_a and op_b are latched into internal mcand/mplier.
  - Accumulator is cleared; count=0; state=CALC.
  - Operands may change freely after edge N.
- Iterations at edges N+1..N+WIDTH:
  - If mplier[0]=1, add mcand into the upper half of the {acc_hi, acc_lo} shift register with a WIDTH+1-bit sum that captures the carry.
  - Shift the combined {carry, acc} right by 1; count++.
- Completion:
  - At edge N+WIDTH, state=DONE and prod_hi/prod_lo are loaded with the final value.
  - done=1 during the cycle after edge N+WIDTH only.
  - Latency from accepting edge to done: WIDTH cycles (16). Fixed; no early-out on zero operands.
- Hold: prod_hi/prod_lo hold their value through DONE and IDLE until the next accepted start. On a start they are not cleared until the new result is written.
- start during CALC is ignored; no queuing.
- Unsigned arithmetic, exact: 0xFFFF*0xFFFF = 0xFFFE_0001; no overflow is possible.
- busy = (state==CALC); ready = (state==IDLE || state==DONE). Both are mutually exclusive, and exactly one of them is 1 out of reset.

Optional Feature:
- Macro: SEQ_MUL_SIGNED_EN.
- Defined: operands are two's complement.
  - At accept, the magnitudes |op_a| and |op_b| are latched as unsigned (0x8000 → 0x8000), and neg = op_a[15]^op_b[15] is recorded.
  - On the final write (edge N+WIDTH), the 32-bit result is two's-complement negated if neg=1.
  - Latency is unchanged.
  - Examples: -3*5 = 0xFFFF_FFF1; -32768*-32768 = 0x4000_0000.
- Undefined: purely unsigned; there is no neg register and no sign logic.

Decomposition:
- Shared package seq_mul_pkg contains:
  - state encoding constants S_IDLE=2'd0, S_CALC=2'd1, S_DONE=2'd2;
  - default WIDTH and CNT_W constants.
- One natural sub-module, mul_sign_fix: combinational abs/negate helper, instantiated only under SEQ_MUL_SIGNED_EN.
- Datapath and FSM stay in seq_multiplier.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, start=0 → ready=1, busy=0, done=0, prod=0x0000_0000.
- Basic: op_a=0x0003, op_b=0x0005, start 1 cycle → busy for 16 cycles, done pulses exactly 16 cycles after accept, prod_hi=0x0000, prod_lo=0x000F; result held 3 cycles later.
- Max: op_a=op_b=0xFFFF → prod_hi=0xFFFE, prod_lo=0x0001. Also op_a=0x1234, op_b=0x0000 → 0x0000_0000 at the same 16-cycle latency.
- Busy-ignore: accept 0x0100*0x0100, pulse start with 0x0002*0x0002 at cycle 5 of CALC → single done, result 0x0001_0000, no second done.
- Back-to-back and mid-op reset:
  - Start asserted in DONE with 0x00FF*0x0101 → new CALC begins immediately, result 0x0000_FFFF.
  - Assert rst at CALC cycle 8 → IDLE next edge, prod=0, no done pulse.
- Signed (with SEQ_MUL_SIGNED_EN): 0xFFFD*0x0005 → 0xFFFF_FFF1; 0x8000*0x8000 → 0x4000_0000; 0xFFFF*0xFFFF → 0x0000_0001.
